// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port RAM arbiter.
// The write-protect window test lives here so the top and any checker agree on it.
package mem_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_t;

  // A window with base above top is empty, which is how protection is disabled.
  function automatic logic in_wp(input int addr, input int base, input int top);
    return (base <= top) && (addr >= base) && (addr <= top);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both requester ports, the lock/error status and the RAM-side lines.
// Handshake: a requester holds req/we/addr/wdata stable until it sees gnt high in the
// same cycle; gnt high means accepted, read data returns with rvalid one cycle later.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) ();
  import mem_arb_pkg::*;

  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_gnt;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata;

  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_gnt;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;

  logic                  b_lock;
  logic                  b_locked;
  logic                  wp_err;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic                  mem_rd;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_dout;

  arb_state_t            dbg_state;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    input  b_lock,
    output b_locked, wp_err,
    output mem_addr, mem_din, mem_rd, mem_we,
    input  mem_dout,
    output dbg_state
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    output b_lock,
    input  b_locked, wp_err,
    input  mem_addr, mem_din, mem_rd, mem_we,
    output mem_dout,
    input  dbg_state
  );

endinterface

// File: rtl/mem_arb_port_rsp.sv
// Per-port read response: rvalid flop plus a hold register so rdata keeps
// showing the last read value once rvalid drops.
module mem_arb_port_rsp #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_rd_issue,
  input  logic [DATA_WIDTH-1:0] i_mem_dout,
  output logic                  o_rvalid,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_hold;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rvalid <= 1'b0;
      r_hold   <= '0;
    end else begin
      r_rvalid <= i_rd_issue;
      if (r_rvalid) begin
        r_hold <= i_mem_dout;
      end
    end
  end

  // The RAM output is live only in the cycle after the read; pass it straight through then.
  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rvalid ? i_mem_dout : r_hold;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port synchronous RAM: round-robin grants,
// a port-B bus lock for halted-CPU access, and a write-protected ROM window.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int WP_BASE    = 0,
  parameter int WP_TOP     = 0
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  port_sel_t             r_last;
  port_sel_t             w_last_nxt;
  port_sel_t             w_win;

  logic                  w_a_gnt;
  logic                  w_b_gnt;
  logic                  w_any_gnt;
  logic                  w_win_we;
  logic                  w_prot;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [DATA_WIDTH-1:0] w_win_data;
  logic                  w_a_rd_issue;
  logic                  w_b_rd_issue;
  logic                  r_wp_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ARB;
      r_last   <= PORT_B;
      r_wp_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_last   <= w_last_nxt;
      r_wp_err <= w_any_gnt && w_win_we && w_prot;
    end
  end

  always_comb begin
    w_a_gnt     = 1'b0;
    w_b_gnt     = 1'b0;
    w_state_nxt = r_state;
    if (!reset) begin
      case (r_state)
        ARB: begin
          if (bus.a_req && bus.b_req) begin
            if (r_last == PORT_B) begin
              w_a_gnt = 1'b1;
            end else begin
              w_b_gnt = 1'b1;
            end
          end else begin
            w_a_gnt = bus.a_req;
            w_b_gnt = bus.b_req;
          end
          // Lock only engages on a cycle where B actually wins the bus.
          if (w_b_gnt && bus.b_lock) begin
            w_state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          w_b_gnt = bus.b_req;
          if (!bus.b_lock) begin
            w_state_nxt = ARB;
          end
        end
        default: w_state_nxt = ARB;
      endcase
    end
  end

  assign w_any_gnt  = w_a_gnt || w_b_gnt;
  assign w_last_nxt = w_b_gnt ? PORT_B : (w_a_gnt ? PORT_A : r_last);

  // Without a grant the winner defaults to A, so the address/data lines idle on A's values.
  assign w_win      = w_b_gnt ? PORT_B : PORT_A;
  assign w_win_we   = (w_win == PORT_B) ? bus.b_we    : bus.a_we;
  assign w_win_addr = (w_win == PORT_B) ? bus.b_addr  : bus.a_addr;
  assign w_win_data = (w_win == PORT_B) ? bus.b_wdata : bus.a_wdata;
  assign w_prot     = in_wp(int'(w_win_addr), WP_BASE, WP_TOP);

  assign bus.a_gnt    = w_a_gnt;
  assign bus.b_gnt    = w_b_gnt;
  assign bus.mem_rd   = w_any_gnt && !w_win_we;
  assign bus.mem_we   = w_any_gnt && w_win_we && !w_prot;
  assign bus.mem_addr = reset ? '0 : w_win_addr;
  assign bus.mem_din  = reset ? '0 : w_win_data;

  assign bus.b_locked  = (r_state == LOCKED);
  assign bus.wp_err    = r_wp_err;
  assign bus.dbg_state = r_state;

  assign w_a_rd_issue = w_a_gnt && !bus.a_we;
  assign w_b_rd_issue = w_b_gnt && !bus.b_we;

  mem_arb_port_rsp #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_a (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_rd_issue (w_a_rd_issue),
    .i_mem_dout (bus.mem_dout),
    .o_rvalid   (bus.a_rvalid),
    .o_rdata    (bus.a_rdata)
  );

  mem_arb_port_rsp #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_b (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_rd_issue (w_b_rd_issue),
    .i_mem_dout (bus.mem_dout),
    .o_rvalid   (bus.b_rvalid),
    .o_rdata    (bus.b_rdata)
  );

endmodule
